dh_sequencer: RTL and testbench
===============================

DH_SEQUENCER -- requirements
Module: dh_sequencer

Interface
REQ-001 SHALL have parameter W, default 32: operand/result width in bits.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1024: watchdog limit in cycles per exponentiation (used only with DH_SEQ_TIMEOUT_EN).
REQ-003 SHALL have port CLK  input  1  the single clock, rising-edge.
REQ-004 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port ST  input  1  start request; sampled only in IDLE.
REQ-006 SHALL have ports G, P, X, Y  input  W each: generator, prime modulus, party-A secret, party-B secret.
REQ-007 SHALL have port EXP_START  output  1  one-cycle start pulse to the shared modular-exponentiation unit.
REQ-008 SHALL have ports EXP_BASE, EXP_EXPO, EXP_MOD  output  W each: operands to that unit, stable from the EXP_START cycle until EXP_DONE.
REQ-009 SHALL have ports EXP_DONE  input  1  and EXP_RESULT  input  W: completion strobe and result, valid in the same cycle.
REQ-010 SHALL have ports BUSY, DONE, MATCH, ERR  output  1 each: sequence active, one-cycle completion pulse, key agreement, abort.
REQ-011 SHALL have ports PUB_A, PUB_B, KEY  output  W each: public values and agreed key.

Function
REQ-012 SHALL implement states IDLE, CHECK, PUB_A, PUB_B, KEY_A, KEY_B, CMP, FIN, FAIL.
REQ-013 SHALL, in IDLE with ST=1, latch G, P, X and Y into internal registers, go to CHECK, and assert BUSY from the next cycle.
REQ-014 SHALL, in CHECK, go to FAIL if P<2, X==0, Y==0 or G>=P; otherwise go to PUB_A.
REQ-015 SHALL run each exponent state as two phases:
- ISSUE: one cycle with EXP_START=1.
- WAIT: hold until EXP_DONE=1.
REQ-016 SHALL use these exponent-state operands:
- PUB_A: G^X mod P.
- PUB_B: G^Y mod P.
- KEY_A: PUB_B^X mod P.
- KEY_B: PUB_A^Y mod P.
REQ-017 SHALL capture EXP_RESULT in the EXP_DONE cycle and advance to the next state on the following edge.
REQ-018 SHALL ignore EXP_DONE outside WAIT.
REQ-019 SHALL never issue EXP_START while a request is outstanding.
REQ-020 SHALL, in CMP, set MATCH=(KEY_A result == KEY_B result), drive KEY with the KEY_A result, and go to FIN.
REQ-021 SHALL, in FIN, pulse DONE for one cycle, deassert BUSY, and return to IDLE.
REQ-022 SHALL, in FAIL, set ERR=1, clear MATCH, pulse DONE for one cycle, and return to IDLE.
REQ-023 SHALL hold PUB_A, PUB_B, KEY, MATCH and ERR stable in IDLE until the next accepted ST, which clears ERR and MATCH.
REQ-024 SHALL ignore ST while BUSY=1, with no queuing.
REQ-025 SHALL give DONE 4 exponentiation latencies plus 11 cycles after ST on the success path.
REQ-026 SHALL, when EXP_DONE arrives in the same cycle as the ISSUE pulse (zero latency), accept it and proceed.

Reset
REQ-027 SHALL, on RST=1, immediately set the state to IDLE, set all outputs and internal registers to 0, and drop any outstanding exponentiation.
REQ-028 SHALL, after RST deasserts, ignore a late EXP_DONE from the dropped request until a new ISSUE.

Configuration
REQ-029 SHALL, with DH_SEQ_TIMEOUT_EN defined, count WAIT cycles and go to FAIL when the count reaches TIMEOUT_CYC without EXP_DONE; the counter clears on every ISSUE.
REQ-030 SHALL, without DH_SEQ_TIMEOUT_EN, contain no counter and wait indefinitely in WAIT.

Structure
REQ-031 SHALL take its state encodings (4-bit) and the default W and TIMEOUT_CYC constants from a shared package dh_pkg.
REQ-032 SHALL place the watchdog in sub-module dh_seq_wdog, instantiated only under DH_SEQ_TIMEOUT_EN.

Verification
REQ-033 SHALL cover: G=5, P=23, X=6, Y=15, engine latency 3 -> PUB_A=8, PUB_B=19, KEY=2, MATCH=1, ERR=0, DONE at cycle 23.
REQ-034 SHALL cover: P=1 with ST -> FAIL, ERR=1, DONE pulse, EXP_START never asserted.
REQ-035 SHALL cover: ST re-asserted mid-sequence, plus a spurious EXP_DONE in IDLE -> no restart and unchanged results.
REQ-036 SHALL cover: RST asserted in KEY_A WAIT -> all outputs 0 at once; a later EXP_DONE is ignored; a fresh run with G=2, P=11, X=3, Y=4 gives KEY=4.
REQ-037 SHALL cover: with DH_SEQ_TIMEOUT_EN and TIMEOUT_CYC=16, the engine never responds -> ERR=1 after 16 WAIT cycles, DONE pulse.
REQ-038 SHALL cover: a faulty engine model returning KEY_B+1 -> MATCH=0, ERR=0, DONE=1.

Source files
------------

// File: rtl/dh_pkg.sv
// Shared definitions for the Diffie-Hellman sequencer.
// - DhDefaultW / DhDefaultTimeoutCyc: default operand width and watchdog limit.
// - dh_state_e: 4-bit top-level sequencer state encoding.
// - dh_phase_e: sub-phase used inside each exponentiation state.
// - is_exp_state / next_exp_state: helpers for walking the four exponent states.
package dh_pkg;

  localparam int unsigned DhDefaultW          = 32;
  localparam int unsigned DhDefaultTimeoutCyc = 1024;

  typedef enum logic [3:0] {
    StIdle  = 4'd0,
    StCheck = 4'd1,
    StPubA  = 4'd2,
    StPubB  = 4'd3,
    StKeyA  = 4'd4,
    StKeyB  = 4'd5,
    StCmp   = 4'd6,
    StFin   = 4'd7,
    StFail  = 4'd8
  } dh_state_e;

  // Issue: start pulse cycle. Wait: request outstanding. Adv: result captured,
  // step to the next state on the following edge.
  typedef enum logic [1:0] {
    PhIssue = 2'd0,
    PhWait  = 2'd1,
    PhAdv   = 2'd2
  } dh_phase_e;

  function automatic logic is_exp_state(dh_state_e s);
    return (s == StPubA) || (s == StPubB) || (s == StKeyA) || (s == StKeyB);
  endfunction

  function automatic dh_state_e next_exp_state(dh_state_e s);
    dh_state_e n;
    case (s)
      StPubA:  n = StPubB;
      StPubB:  n = StKeyA;
      StKeyA:  n = StKeyB;
      default: n = StCmp;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/dh_seq_wdog.sv
// Per-exponentiation watchdog for the DH sequencer.
// Ports:
//   clk_i, rst_i  - clock and asynchronous active-high reset
//   clr_i         - clears the count (asserted on every issue cycle)
//   cnt_en_i      - one wait cycle elapsed without a completion strobe
//   expired_o     - high in the TimeoutCyc-th counted wait cycle
module dh_seq_wdog #(
  parameter int unsigned TimeoutCyc = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic cnt_en_i,
  output logic expired_o
);

  localparam int unsigned CntW = (TimeoutCyc > 1) ? $clog2(TimeoutCyc) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_en_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Count holds the number of wait cycles already elapsed, so the limit is hit
  // in the cycle where it equals TimeoutCyc-1.
  assign expired_o = cnt_en_i && (cnt_q == CntW'(TimeoutCyc - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dh_sequencer.sv
// Diffie-Hellman key-agreement sequencer driving a shared modular-exponentiation
// unit: PUB_A = G^X, PUB_B = G^Y, then both keys, compared for agreement.
// Optional watchdog on each exponentiation when DH_SEQ_TIMEOUT_EN is defined.
// Ports:
//   CLK, RST                   - clock, asynchronous active-high reset
//   ST, G, P, X, Y             - start request and operands (latched on accept)
//   EXP_START/BASE/EXPO/MOD    - request to the exponentiation unit
//   EXP_DONE, EXP_RESULT       - completion strobe and result from that unit
//   BUSY, DONE, MATCH, ERR     - status; DONE is a one-cycle pulse
//   PUB_A, PUB_B, KEY          - public values and agreed key
module dh_sequencer import dh_pkg::*; #(
  parameter int unsigned W           = DhDefaultW,
  parameter int unsigned TIMEOUT_CYC = DhDefaultTimeoutCyc
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         ST,
  input  logic [W-1:0] G,
  input  logic [W-1:0] P,
  input  logic [W-1:0] X,
  input  logic [W-1:0] Y,
  output logic         EXP_START,
  output logic [W-1:0] EXP_BASE,
  output logic [W-1:0] EXP_EXPO,
  output logic [W-1:0] EXP_MOD,
  input  logic         EXP_DONE,
  input  logic [W-1:0] EXP_RESULT,
  output logic         BUSY,
  output logic         DONE,
  output logic         MATCH,
  output logic         ERR,
  output logic [W-1:0] PUB_A,
  output logic [W-1:0] PUB_B,
  output logic [W-1:0] KEY
);

  dh_state_e state_q, state_d;
  dh_phase_e phase_q, phase_d;

  logic [W-1:0] g_q, g_d, p_q, p_d, x_q, x_d, y_q, y_d;
  logic [W-1:0] pub_a_q, pub_a_d, pub_b_q, pub_b_d;
  logic [W-1:0] key_a_q, key_a_d, key_b_q, key_b_d, key_q, key_d;
  logic [W-1:0] base_q, base_d, expo_q, expo_d, mod_q, mod_d;
  logic         start_q, start_d, busy_q, busy_d, done_q, done_d;
  logic         match_q, match_d, err_q, err_d;
  logic         wait_idle, wdog_expired;

  // A counted wait cycle: request outstanding and no completion this cycle.
  assign wait_idle = is_exp_state(state_q) && (phase_q == PhWait) && !EXP_DONE;

`ifdef DH_SEQ_TIMEOUT_EN
  dh_seq_wdog #(
    .TimeoutCyc(TIMEOUT_CYC)
  ) u_wdog (
    .clk_i    (CLK),
    .rst_i    (RST),
    .clr_i    (start_q),
    .cnt_en_i (wait_idle),
    .expired_o(wdog_expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = wait_idle | (TIMEOUT_CYC == 0);
  assign wdog_expired   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    g_d     = g_q;
    p_d     = p_q;
    x_d     = x_q;
    y_d     = y_q;
    pub_a_d = pub_a_q;
    pub_b_d = pub_b_q;
    key_a_d = key_a_q;
    key_b_d = key_b_q;
    key_d   = key_q;
    base_d  = base_q;
    expo_d  = expo_q;
    mod_d   = mod_q;
    match_d = match_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle: begin
        if (ST) begin
          g_d     = G;
          p_d     = P;
          x_d     = X;
          y_d     = Y;
          err_d   = 1'b0;
          match_d = 1'b0;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if ((p_q < W'(2)) || (x_q == '0) || (y_q == '0) || (g_q >= p_q)) begin
          state_d = StFail;
        end else begin
          state_d = StPubA;
          phase_d = PhIssue;
        end
      end
      StPubA, StPubB, StKeyA, StKeyB: begin
        unique case (phase_q)
          PhIssue, PhWait: begin
            // Completion in the issue cycle itself is a zero-latency response.
            if (EXP_DONE) begin
              unique case (state_q)
                StPubA:  pub_a_d = EXP_RESULT;
                StPubB:  pub_b_d = EXP_RESULT;
                StKeyA:  key_a_d = EXP_RESULT;
                default: key_b_d = EXP_RESULT;
              endcase
              phase_d = PhAdv;
            end else if (phase_q == PhIssue) begin
              phase_d = PhWait;
            end else if (wdog_expired) begin
              state_d = StFail;
            end
          end
          default: begin
            state_d = next_exp_state(state_q);
            phase_d = PhIssue;
          end
        endcase
      end
      StCmp: begin
        match_d = (key_a_q == key_b_q);
        key_d   = key_a_q;
        state_d = StFin;
      end
      default: state_d = StIdle;  // StFin, StFail
    endcase

    if (state_d == StFail) begin
      err_d   = 1'b1;
      match_d = 1'b0;
    end

    // Outputs are registered, so they are derived from the next state.
    start_d = is_exp_state(state_d) && (phase_d == PhIssue);
    busy_d  = !((state_d == StIdle) || (state_d == StFin) || (state_d == StFail));
    done_d  = (state_d == StFin) || (state_d == StFail);

    if (start_d) begin
      mod_d = p_q;
      unique case (state_d)
        StPubA: begin base_d = g_q;     expo_d = x_q; end
        StPubB: begin base_d = g_q;     expo_d = y_q; end
        StKeyA: begin base_d = pub_b_q; expo_d = x_q; end
        default: begin base_d = pub_a_q; expo_d = y_q; end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      phase_q <= PhIssue;
      g_q     <= '0;
      p_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      pub_a_q <= '0;
      pub_b_q <= '0;
      key_a_q <= '0;
      key_b_q <= '0;
      key_q   <= '0;
      base_q  <= '0;
      expo_q  <= '0;
      mod_q   <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      g_q     <= g_d;
      p_q     <= p_d;
      x_q     <= x_d;
      y_q     <= y_d;
      pub_a_q <= pub_a_d;
      pub_b_q <= pub_b_d;
      key_a_q <= key_a_d;
      key_b_q <= key_b_d;
      key_q   <= key_d;
      base_q  <= base_d;
      expo_q  <= expo_d;
      mod_q   <= mod_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      match_q <= match_d;
      err_q   <= err_d;
    end
  end

  assign EXP_START = start_q;
  assign EXP_BASE  = base_q;
  assign EXP_EXPO  = expo_q;
  assign EXP_MOD   = mod_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign MATCH     = match_q;
  assign ERR       = err_q;
  assign PUB_A     = pub_a_q;
  assign PUB_B     = pub_b_q;
  assign KEY       = key_q;

endmodule

// File: tb/tb_dh_sequencer.sv
// Bench for dh_sequencer: a behavioural exponentiation engine with configurable
// latency, a table of runs checked through a scoreboard queue, and hand-written
// sequences for restart, spurious strobes, mid-run reset, faulty engine and
// (with DH_SEQ_TIMEOUT_EN) the watchdog.
module tb_dh_sequencer;

  localparam int unsigned W = 32;

  logic         CLK = 1'b0;
  logic         RST;
  logic         ST;
  logic [W-1:0] G, P, X, Y;
  logic         EXP_START;
  logic [W-1:0] EXP_BASE, EXP_EXPO, EXP_MOD;
  logic         EXP_DONE = 1'b0;
  logic [W-1:0] EXP_RESULT = '0;
  logic         BUSY, DONE, MATCH, ERR;
  logic [W-1:0] PUB_A, PUB_B, KEY;

  dh_sequencer #(
    .W          (W),
    .TIMEOUT_CYC(16)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .ST        (ST),
    .G         (G),
    .P         (P),
    .X         (X),
    .Y         (Y),
    .EXP_START (EXP_START),
    .EXP_BASE  (EXP_BASE),
    .EXP_EXPO  (EXP_EXPO),
    .EXP_MOD   (EXP_MOD),
    .EXP_DONE  (EXP_DONE),
    .EXP_RESULT(EXP_RESULT),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .MATCH     (MATCH),
    .ERR       (ERR),
    .PUB_A     (PUB_A),
    .PUB_B     (PUB_B),
    .KEY       (KEY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] g, p, x, y;
    int          lat;
    logic [31:0] pa, pb, key;
    logic        match, err;
    int          cyc;
    int          starts;
    bit          chk_vals;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t sb_q[$];
  vec_t vecs[11];

  // Engine model state
  int          lat_cfg = 0;
  bit          no_resp = 0, fault_keyb = 0, inj_done = 0;
  logic [31:0] inj_res = '0;
  int          total_starts = 0, run_base = 0;
  bit          pend = 0, overlap_err = 0, stab_err = 0;
  int          cnt = 0;
  logic [31:0] res = '0, sv_base = '0, sv_expo = '0, sv_mod = '0;

  function automatic logic [31:0] modexp(logic [31:0] b, logic [31:0] e, logic [31:0] m);
    logic [63:0] r, bb;
    if (m == 0) return 32'd0;
    r  = 64'(32'd1 % m);
    bb = 64'(b % m);
    for (int i = 0; i < 32; i++) begin
      if (e[i]) r = (r * bb) % 64'(m);
      bb = (bb * bb) % 64'(m);
    end
    return r[31:0];
  endfunction

  always @(negedge CLK) begin
    EXP_DONE = 1'b0;
    if (RST) begin
      pend = 0;
    end else begin
      if (pend && (EXP_BASE !== sv_base || EXP_EXPO !== sv_expo || EXP_MOD !== sv_mod))
        stab_err = 1;
      if (EXP_START) begin
        if (pend) overlap_err = 1;
        res = modexp(EXP_BASE, EXP_EXPO, EXP_MOD);
        if (fault_keyb && (total_starts - run_base == 3)) res = res + 32'd1;
        sv_base = EXP_BASE;
        sv_expo = EXP_EXPO;
        sv_mod  = EXP_MOD;
        total_starts++;
        pend = !no_resp;
        cnt  = lat_cfg;
      end
      if (pend) begin
        if (cnt == 0) begin
          EXP_DONE   = 1'b1;
          EXP_RESULT = res;
          pend       = 0;
        end else begin
          cnt--;
        end
      end
      if (inj_done) begin
        EXP_DONE   = 1'b1;
        EXP_RESULT = inj_res;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, req);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_bit({tag, "_busy"}, BUSY, 1'b0);
    check_bit({tag, "_done"}, DONE, 1'b0);
    check_bit({tag, "_match"}, MATCH, 1'b0);
    check_bit({tag, "_err"}, ERR, 1'b0);
    check_bit({tag, "_exp_start"}, EXP_START, 1'b0);
    check_val({tag, "_pub_a"}, PUB_A, 32'd0);
    check_val({tag, "_pub_b"}, PUB_B, 32'd0);
    check_val({tag, "_key"}, KEY, 32'd0);
    check_val({tag, "_exp_base"}, EXP_BASE, 32'd0);
  endtask

  function automatic vec_t mk(logic [31:0] g, logic [31:0] p, logic [31:0] x, logic [31:0] y,
                              int lat, logic [31:0] pa, logic [31:0] pb, logic [31:0] key,
                              logic match, logic err, int cyc, int starts, bit chk);
    vec_t v;
    v.g = g; v.p = p; v.x = x; v.y = y; v.lat = lat;
    v.pa = pa; v.pb = pb; v.key = key; v.match = match; v.err = err;
    v.cyc = cyc; v.starts = starts; v.chk_vals = chk;
    return v;
  endfunction

  // One complete run: ST in cycle 0, expected record pushed to the scoreboard,
  // popped and compared when DONE appears. mid_st re-asserts ST with other
  // operands while the run is active.
  task automatic do_run(input vec_t v, input bit mid_st);
    int   base, cyc;
    vec_t e;
    lat_cfg  = v.lat;
    run_base = total_starts;
    base     = total_starts;
    G = v.g; P = v.p; X = v.x; Y = v.y;
    ST = 1'b1;
    sb_q.push_back(v);
    tick();
    ST  = 1'b0;
    cyc = 1;
    check_bit("busy_after_st", BUSY, 1'b1);
    check_bit("err_cleared_on_st", ERR, 1'b0);
    check_bit("match_cleared_on_st", MATCH, 1'b0);
    while (!DONE && cyc < 400) begin
      if (mid_st && cyc >= 3 && cyc <= 6) begin
        ST = 1'b1; G = 32'd7; P = 32'd13; X = 32'd2; Y = 32'd2;
      end else begin
        ST = 1'b0;
      end
      tick();
      cyc++;
    end
    ST = 1'b0;
    if (!DONE) begin
      check_bit("done_within_budget", DONE, 1'b1);
      void'(sb_q.pop_front());
      return;
    end
    if (sb_q.size() == 0) begin
      check_val("scoreboard_nonempty", 32'd0, 32'd1);
      return;
    end
    e = sb_q.pop_front();
    check_val("done_cycle", cyc, e.cyc);
    check_bit("err", ERR, e.err);
    check_bit("match", MATCH, e.match);
    check_bit("busy_at_done", BUSY, 1'b0);
    check_val("exp_starts", total_starts - base, e.starts);
    if (e.chk_vals) begin
      check_val("pub_a", PUB_A, e.pa);
      check_val("pub_b", PUB_B, e.pb);
      check_val("key", KEY, e.key);
    end
    tick();
    check_bit("done_one_cycle", DONE, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation did not complete, expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    int   b;
    vec_t v;
    vecs[0]  = mk(5, 23, 6, 15, 3, 8, 19, 2, 1'b1, 1'b0, 23, 4, 1);
    vecs[1]  = mk(2, 11, 3, 4, 0, 8, 5, 4, 1'b1, 1'b0, 11, 4, 1);
    vecs[2]  = mk(2, 11, 3, 4, 1, 8, 5, 4, 1'b1, 1'b0, 15, 4, 1);
    vecs[3]  = mk(3, 17, 4, 5, 2, 13, 5, 13, 1'b1, 1'b0, 19, 4, 1);
    vecs[4]  = mk(1, 2, 5, 7, 0, 1, 1, 1, 1'b1, 1'b0, 11, 4, 1);
    vecs[5]  = mk(0, 1, 1, 1, 3, 0, 0, 0, 1'b0, 1'b1, 2, 0, 0);
    vecs[6]  = mk(23, 23, 6, 15, 3, 0, 0, 0, 1'b0, 1'b1, 2, 0, 0);
    vecs[7]  = mk(5, 23, 0, 15, 3, 0, 0, 0, 1'b0, 1'b1, 2, 0, 0);
    vecs[8]  = mk(5, 23, 6, 0, 3, 0, 0, 0, 1'b0, 1'b1, 2, 0, 0);
    vecs[9]  = mk(4, 23, 5, 9, 5, 12, 13, 4, 1'b1, 1'b0, 31, 4, 1);
    vecs[10] = mk(0, 0, 1, 1, 0, 0, 0, 0, 1'b0, 1'b1, 2, 0, 0);

    RST = 1'b1; ST = 1'b0; G = '0; P = '0; X = '0; Y = '0;
    tick();
    tick();
    check_all_zero("reset");
    RST = 1'b0;
    tick();

    foreach (vecs[i]) do_run(vecs[i], 1'b0);

    // Restart attempts mid-run, then a spurious strobe while idle.
    do_run(vecs[0], 1'b1);
    b = total_starts;
    inj_res  = 32'd99;
    inj_done = 1'b1;
    tick();
    inj_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_bit("idle_no_done", DONE, 1'b0);
      check_bit("idle_no_busy", BUSY, 1'b0);
    end
    check_val("idle_no_start", total_starts - b, 0);
    check_val("idle_pub_a_held", PUB_A, 32'd8);
    check_val("idle_pub_b_held", PUB_B, 32'd19);
    check_val("idle_key_held", KEY, 32'd2);
    check_bit("idle_match_held", MATCH, 1'b1);

    // Engine returns KEY_B + 1: disagreement but no error.
    fault_keyb = 1;
    v = vecs[0];
    v.match = 1'b0;
    do_run(v, 1'b0);
    fault_keyb = 0;

    // Reset while KEY_A is outstanding, then a late strobe from the dropped request.
    lat_cfg  = 3;
    run_base = total_starts;
    b        = total_starts;
    G = 32'd5; P = 32'd23; X = 32'd6; Y = 32'd15;
    ST = 1'b1;
    tick();
    ST = 1'b0;
    for (int i = 0; i < 100 && (total_starts - b) < 3; i++) tick();
    check_val("reached_key_a", total_starts - b, 3);
    tick();
    #1 RST = 1'b1;
    #1 check_all_zero("async_reset");
    tick();
    RST = 1'b0;
    inj_res  = 32'd77;
    inj_done = 1'b1;
    tick();
    inj_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all_zero("after_late_done");
    end
    do_run(mk(2, 11, 3, 4, 3, 8, 5, 4, 1'b1, 1'b0, 23, 4, 1), 1'b0);

`ifdef DH_SEQ_TIMEOUT_EN
    no_resp = 1;
    do_run(mk(5, 23, 6, 15, 3, 0, 0, 0, 1'b0, 1'b1, 19, 1, 0), 1'b0);
    no_resp = 0;
`endif

    check_bit("no_issue_while_outstanding", overlap_err, 1'b0);
    check_bit("operands_stable_while_outstanding", stab_err, 1'b0);
    check_val("scoreboard_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
